// File: rtl/aes_pkg.sv
// AES-128 shared types and GF(2^8) helpers.
// S-boxes, Rcon table, inverse key step, FSM enum.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ROUND,
      DONE
   } fsm_t;

   localparam logic [10:1][7:0] RCON = {
      8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
      8'h10, 8'h08, 8'h04, 8'h02, 8'h01
   };

   function automatic logic [7:0] rcon(input logic [3:0] i);
      logic [7:0] rc;
      rc = 8'h00;
      if (i >= 4'd1 && i <= 4'd10) rc = RCON[i];
      return rc;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   function automatic logic [7:0] gmul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 (addition chain), 0 maps to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gmul(x, x);
      x3   = gmul(x2, x);
      x12  = gmul(gmul(x3, x3), gmul(x3, x3));
      x15  = gmul(x12, x3);
      x240 = gmul(x15, x15);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      x240 = gmul(x240, x240);
      return gmul(gmul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] rotl8(
      input logic [7:0] a,
      input int         n
   );
      logic [15:0] t;
      t = {a, a} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2)
           ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      logic [7:0] v;
      v = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
      return gf_inv(v);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]),
              sbox(w[15:8]),  sbox(w[7:0])};
   endfunction

   // Walk the key schedule one round backwards.
   function automatic logic [127:0] inv_key_step(
      input logic [127:0] key,
      input logic [7:0]   rc
   );
      logic [31:0] w0, w1, w2, w3;
      w3 = key[31:0]  ^ key[63:32];
      w2 = key[63:32] ^ key[95:64];
      w1 = key[95:64] ^ key[127:96];
      w0 = key[127:96]
         ^ sub_word({w3[23:0], w3[31:24]})
         ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round.
// state_in/round_key in, state_out; is_last_round bypasses InvMixColumns.
module aes_inv_round (
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         is_last_round,
   output logic [127:0] state_out
);
   import aes_pkg::*;

   logic [127:0] shifted;
   logic [127:0] keyed;
   logic [127:0] mixed;

   function automatic logic [7:0] byte_at(
      input logic [127:0] v,
      input int           i
   );
      return v[127-8*i -: 8];
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = w;
      return {
         gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b)
       ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
         gmul(a0, 8'h09) ^ gmul(a1, 8'h0e)
       ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
         gmul(a0, 8'h0d) ^ gmul(a1, 8'h09)
       ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
         gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d)
       ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)
      };
   endfunction

   always_comb begin
      shifted = '0;
      keyed   = '0;
      mixed   = '0;
      // Row r rotates right by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shifted[127-8*(4*c+r) -: 8] =
               byte_at(state_in, 4*((c-r+4)%4)+r);
         end
      end
      for (int i = 0; i < 16; i++) begin
         keyed[127-8*i -: 8] =
            inv_sbox(byte_at(shifted, i))
            ^ byte_at(round_key, i);
      end
      for (int c = 0; c < 4; c++) begin
         mixed[127-32*c -: 32] =
            inv_mix_col(keyed[127-32*c -: 32]);
      end
   end

   assign state_out = is_last_round ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse round per clock.
// in_*: ciphertext + round-10 key; out_*: plaintext; valid/ready both sides.
module aes_decrypt_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data
);
   import aes_pkg::*;

   fsm_t         fsm;
   logic [3:0]   rnd;
   logic [127:0] state_reg;
   logic [127:0] key_reg;
   logic [127:0] next_key;
   logic [127:0] round_out;
   logic         last_round;

   assign last_round = (rnd == 4'd0);
   // Round r needs Rcon[r+1] to step back from key r+1.
   assign next_key = inv_key_step(key_reg, rcon(rnd + 4'd1));

   aes_inv_round u_round (
      .state_in      (state_reg),
      .round_key     (next_key),
      .is_last_round (last_round),
      .state_out     (round_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm       <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_data  <= '0;
         rnd       <= 4'd0;
         state_reg <= '0;
         key_reg   <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state_reg <= in_data ^ in_key;
                  key_reg   <= in_key;
                  rnd       <= 4'd9;
                  in_ready  <= 1'b0;
                  fsm       <= ROUND;
               end
            end
            ROUND: begin
               state_reg <= round_out;
               key_reg   <= next_key;
               if (last_round) begin
                  out_data  <= round_out;
                  out_valid <= 1'b1;
                  fsm       <= DONE;
               end else begin
                  rnd <= rnd - 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  fsm       <= IDLE;
               end
            end
            default: begin
               fsm       <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Scoreboard bench for aes_decrypt_iter.
// Directed FIPS-197 vectors plus random round-trips from an encrypt model.
module tb_aes_decrypt_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_data;

   localparam logic [127:0] K1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;

   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   logic [127:0] exp_q [$];
   logic [7:0]   sb [256];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   aes_decrypt_iter dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   task automatic check(
      input string        name,
      input logic [127:0] act,
      input logic [127:0] exp
   );
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out: got %h want none", out_data);
         end else begin
            check("scoreboard", out_data, exp_q.pop_front());
         end
      end
   end

   function automatic logic [7:0] tb_mul(
      input logic [7:0] a,
      input logic [7:0] b
   );
      logic [7:0] p, x, y;
      p = 8'h00;
      x = a;
      y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, b, c;
      c = 8'h63;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (tb_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         for (int i = 0; i < 8; i++)
            b[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
                 ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
         sb[x] = b;
      end
   endtask

   task automatic encrypt(
      input  logic [127:0] key,
      input  logic [127:0] pt,
      output logic [127:0] ct,
      output logic [127:0] rk10
   );
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      logic [7:0]  s [16];
      logic [7:0]  t [16];
      logic [7:0]  a0, a1, a2, a3;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sb[tmp[23:16]], sb[tmp[15:8]],
                   sb[tmp[7:0]],   sb[tmp[31:24]]} ^ {rc, 24'h0};
            rc = tb_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++)
         s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
         for (int c = 0; c < 4; c++)
            for (int q = 0; q < 4; q++)
               s[4*c+q] = t[4*((c+q)%4)+q];
         if (r < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c];
               a1 = s[4*c+1];
               a2 = s[4*c+2];
               a3 = s[4*c+3];
               s[4*c]   = tb_mul(a0, 2) ^ tb_mul(a1, 3) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ tb_mul(a1, 2) ^ tb_mul(a2, 3) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ tb_mul(a2, 2) ^ tb_mul(a3, 3);
               s[4*c+3] = tb_mul(a0, 3) ^ a1 ^ a2 ^ tb_mul(a3, 2);
            end
         end
         for (int i = 0; i < 16; i++)
            s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      rk10 = {w[40], w[41], w[42], w[43]};
   endtask

   task automatic send(
      input  logic [127:0] key,
      input  logic [127:0] data,
      input  logic [127:0] exp,
      output int           acc_cyc
   );
      logic rdy;
      logic ok;
      ok = 1'b0;
      acc_cyc = -1;
      in_key = key;
      in_data = data;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk);
         #1;
         if (rdy) begin
            ok = 1'b1;
            acc_cyc = cyc;
            exp_q.push_back(exp);
         end
      end
      in_valid = 1'b0;
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_key = {$urandom, $urandom, $urandom, $urandom};
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL accept_timeout: got no accept want accept");
      end
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++)
         @(posedge clk);
      #1;
      check(name, 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      int a1, a2;
      logic [127:0] k, p, c, rk;
      logic seen;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      in_key = '0;
      out_ready = 1'b1;
      build_sbox();

      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 128'(in_ready), 128'd1);
      check("rst_out_valid", 128'(out_valid), 128'd0);
      check("rst_out_data", out_data, 128'd0);
      rst = 1'b0;

      // C.1 with latency
      send(K1, C1, P1, a1);
      repeat (9) @(posedge clk);
      #1;
      check("lat_edge10", 128'(out_valid), 128'd0);
      @(posedge clk);
      #1;
      check("lat_edge11", 128'(out_valid), 128'd1);
      check("c1_data", out_data, P1);
      drain("c1_drain");

      // A.1 with backpressure
      out_ready = 1'b0;
      send(K2, C2, P2, a1);
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge clk);
         seen = out_valid;
      end
      check("bp_valid_seen", 128'(seen), 128'd1);
      in_key = K1;
      in_data = C1;
      in_valid = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("bp_data", out_data, P2);
         check("bp_in_ready", 128'(in_ready), 128'd0);
         check("bp_out_valid", 128'(out_valid), 128'd1);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("bp_idle_after", 128'(in_ready), 128'd1);
      check("bp_no_extra", 128'(out_valid), 128'd0);
      drain("bp_drain");

      // back-to-back
      send(K1, C1, P1, a1);
      send(K2, C2, P2, a2);
      check("b2b_spacing", 128'(a2 - a1), 128'd12);
      drain("b2b_drain");

      // reset after round 4 is loaded
      send(K2, C2, P2, a1);
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("mid_rst_in_ready", 128'(in_ready), 128'd1);
      check("mid_rst_out_valid", 128'(out_valid), 128'd0);
      rst = 1'b0;
      send(K1, C1, P1, a1);
      drain("mid_rst_drain");

      // random round-trips
      for (int n = 0; n < 1000; n++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         p = {$urandom, $urandom, $urandom, $urandom};
         encrypt(k, p, c, rk);
         send(rk, c, p, a1);
      end
      drain("rand_drain");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
